// File: rtl/riscv_pkg.sv
// Definitions shared between the RISC-V core and its peripherals.
package riscv_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with registered empty/full flags and a drop strobe
// for pushes refused while full.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && !empty_q;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        do_push  = push_i && (!full_q || do_pop);
        drop_o   = push_i && !do_push;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
        empty_d = (count_d == '0);
        full_d  = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/a0_uart_tx.sv
// Serialises every change of the core's a0 low byte as an 8N1 UART frame,
// queuing bursts in a small FIFO and pulsing irq_o per completed frame.
module a0_uart_tx
    import riscv_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       full_o,
    output logic       overflow_o,
    output logic       irq_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    prev_q, prev_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;

    logic          push, pop, baud_last;
    logic [7:0]    fifo_dout;
    logic          fifo_empty, fifo_full, fifo_drop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .din_i   (data_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    // prev tracks data_i even when the byte is dropped.
    always_comb begin
        push   = (data_i != prev_q);
        prev_d = data_i;
        ovf_d  = ovf_q | fifo_drop;
    end

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        irq_d   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
                    else                                  bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d = '0;
                    irq_d  = 1'b1;
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= '0;
            tx_q    <= UART_IDLE;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != IDLE);
    assign full_o     = fifo_full;
    assign overflow_o = ovf_q;
    assign irq_o      = irq_q;

endmodule
